cte_mode_arbiter: RTL and testbench

Shares one CTE colour-transform engine between two requesters. Requester A streams YUV 4:2:2 bytes (YUV→RGB, op_mode 0); requester B streams RGB words (RGB→YUV, op_mode 1). The block grants whole bursts round-robin, drives op_mode, in_en and the input data, honours busy, and routes out_valid to the owning requester. It never switches mode while results are still outstanding.

---
 rtl/cte_arb_pkg.sv | 27 ++
 rtl/cte_arb_rr.sv | 28 ++
 rtl/cte_mode_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cte_mode_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cte_arb_pkg.sv
// Shared types and constants for the CTE mode arbiter.
package cte_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STREAM,
    DRAIN,
    DONE
  } arb_state_e;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_e;

  localparam logic MODE_YUV2RGB = 1'b0;
  localparam logic MODE_RGB2YUV = 1'b1;

  localparam int unsigned YUV_BEATS_PER_PIX = 2;
  localparam int unsigned YUV_OUT_PER_PIX   = 2;

  function automatic logic [1:0] owner_onehot(input owner_e o);
    return (o == OWN_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cte_arb_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side not served last.
module cte_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       served_b_i,
  output logic [1:0] pick_o
);

  logic prio_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_b_q <= 1'b0;
    end else if (upd_i) begin
      prio_b_q <= !served_b_i;
    end
  end

  always_comb begin
    pick_o = req_i;
    if (req_i == 2'b11) begin
      pick_o = prio_b_q ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/cte_mode_arbiter.sv
// Shares one CTE colour-transform engine between a YUV->RGB (A) and an RGB->YUV (B) requester.
// Optional drain watchdog with err_timeout port: define CTE_ARB_WATCHDOG_EN.
module cte_mode_arbiter
  import cte_arb_pkg::*;
#(
  parameter int unsigned LEN_W    = 10,
  parameter int unsigned DRAIN_TO = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic [LEN_W-1:0] a_len,
  input  logic             a_valid,
  input  logic [7:0]       a_yuv,
  output logic             a_ready,
  output logic             a_out_valid,
  output logic             a_done,
  input  logic             b_req,
  input  logic [LEN_W-1:0] b_len,
  input  logic             b_valid,
  input  logic [23:0]      b_rgb,
  output logic             b_ready,
  output logic             b_out_valid,
  output logic             b_done,
  output logic             cte_op_mode,
  output logic             cte_in_en,
  output logic [7:0]       cte_yuv_in,
  output logic [23:0]      cte_rgb_in,
  input  logic             cte_busy,
  input  logic             cte_out_valid,
  output logic             err_stray,
`ifdef CTE_ARB_WATCHDOG_EN
  output logic             err_timeout,
`endif
  output logic [1:0]       grant
);

  localparam int unsigned CW = LEN_W + 1;
  typedef logic [CW-1:0] cnt_t;

  arb_state_e       state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             mode_q, mode_d;
  cnt_t             beats_q, beats_d;
  cnt_t             exp_q, exp_d;
  logic             stray_q, stray_d;
  logic [1:0]       pick;
  logic             rr_upd;
  logic             wd_fire;
  logic             streaming, own_a, own_b;
  logic             res_ok, res_take;
  logic [LEN_W-1:0] sel_len;

  cte_arb_rr u_rr (
    .clk        (clk),
    .rst_n      (reset),
    .req_i      ({b_req, a_req}),
    .upd_i      (rr_upd),
    .served_b_i (owner_q == OWN_B),
    .pick_o     (pick)
  );

  assign streaming = (state_q == STREAM);
  assign own_a     = (owner_q == OWN_A);
  assign own_b     = (owner_q == OWN_B);
  assign res_ok    = ((state_q == STREAM) || (state_q == DRAIN)) && (exp_q != '0);
  assign res_take  = cte_out_valid && res_ok;
  assign sel_len   = pick[1] ? b_len : a_len;

  assign a_ready     = streaming && own_a && !cte_busy;
  assign b_ready     = streaming && own_b && !cte_busy;
  assign cte_in_en   = (a_ready && a_valid) || (b_ready && b_valid);
  assign cte_yuv_in  = (streaming && own_a) ? a_yuv : '0;
  assign cte_rgb_in  = (streaming && own_b) ? b_rgb : '0;
  assign a_out_valid = res_take && own_a;
  assign b_out_valid = res_take && own_b;
  assign a_done      = (state_q == DONE) && own_a;
  assign b_done      = (state_q == DONE) && own_b;
  assign cte_op_mode = mode_q;
  assign err_stray   = stray_q;

  // The winner is already visible in the IDLE decision cycle; reset holds it low.
  assign grant = (state_q == IDLE) ? (reset ? pick : 2'b00) : owner_onehot(owner_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      mode_q  <= MODE_YUV2RGB;
      beats_q <= '0;
      exp_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      mode_q  <= mode_d;
      beats_q <= beats_d;
      exp_q   <= exp_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    mode_d  = mode_q;
    beats_d = beats_q;
    exp_d   = exp_q;
    stray_d = stray_q;
    rr_upd  = 1'b0;

    if (res_take) begin
      exp_d = exp_q - cnt_t'(1);
    end else if (cte_out_valid) begin
      stray_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pick != 2'b00) begin
          state_d = SETUP;
          if (pick[1]) begin
            owner_d = OWN_B;
            mode_d  = MODE_RGB2YUV;
            beats_d = cnt_t'(sel_len);
            exp_d   = cnt_t'(sel_len) * cnt_t'(YUV_OUT_PER_PIX);
          end else begin
            owner_d = OWN_A;
            mode_d  = MODE_YUV2RGB;
            beats_d = cnt_t'(sel_len) * cnt_t'(YUV_BEATS_PER_PIX);
            exp_d   = cnt_t'(sel_len);
          end
        end
      end
      SETUP:  state_d = (beats_q == '0) ? DONE : STREAM;
      STREAM: begin
        if (cte_in_en) begin
          beats_d = beats_q - cnt_t'(1);
          if (beats_q == cnt_t'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      // Look at the post-strobe count so DONE follows the last result directly.
      DRAIN: begin
        if ((exp_d == '0) || wd_fire) begin
          state_d = DONE;
        end
      end
      DONE: begin
        rr_upd  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CTE_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(DRAIN_TO + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q;

  always_comb begin
    wd_d = '0;
    if ((state_q == DRAIN) && !cte_out_valid) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  assign wd_fire     = (state_q == DRAIN) && !cte_out_valid && (wd_q == WD_W'(DRAIN_TO - 1));
  assign err_timeout = timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unused_drain_to;

  assign wd_fire         = 1'b0;
  assign unused_drain_to = ^DRAIN_TO;
`endif

endmodule

// File: tb/tb_cte_mode_arbiter.sv
// Directed self-checking bench for cte_mode_arbiter (watchdog case only with CTE_ARB_WATCHDOG_EN).
module tb_cte_mode_arbiter;

  localparam int unsigned LEN_W = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_req, a_valid, a_ready, a_out_valid, a_done;
  logic [LEN_W-1:0] a_len;
  logic [7:0]       a_yuv;
  logic             b_req, b_valid, b_ready, b_out_valid, b_done;
  logic [LEN_W-1:0] b_len;
  logic [23:0]      b_rgb;
  logic             cte_op_mode, cte_in_en, cte_busy, cte_out_valid, err_stray;
  logic [7:0]       cte_yuv_in;
  logic [23:0]      cte_rgb_in;
  logic [1:0]       grant;
`ifdef CTE_ARB_WATCHDOG_EN
  logic             err_timeout;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cte_mode_arbiter #(.LEN_W(LEN_W), .DRAIN_TO(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .a_req         (a_req),
    .a_len         (a_len),
    .a_valid       (a_valid),
    .a_yuv         (a_yuv),
    .a_ready       (a_ready),
    .a_out_valid   (a_out_valid),
    .a_done        (a_done),
    .b_req         (b_req),
    .b_len         (b_len),
    .b_valid       (b_valid),
    .b_rgb         (b_rgb),
    .b_ready       (b_ready),
    .b_out_valid   (b_out_valid),
    .b_done        (b_done),
    .cte_op_mode   (cte_op_mode),
    .cte_in_en     (cte_in_en),
    .cte_yuv_in    (cte_yuv_in),
    .cte_rgb_in    (cte_rgb_in),
    .cte_busy      (cte_busy),
    .cte_out_valid (cte_out_valid),
    .err_stray     (err_stray),
`ifdef CTE_ARB_WATCHDOG_EN
    .err_timeout   (err_timeout),
`endif
    .grant         (grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_len = '0; a_valid = 0; a_yuv = '0;
    b_req = 0; b_len = '0; b_valid = 0; b_rgb = '0;
    cte_busy = 0; cte_out_valid = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 0;
    adv();
    adv();
    #2;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_mode", 32'(cte_op_mode), 0);
    chk("rst_inen", 32'(cte_in_en), 0);
    chk("rst_stray", 32'(err_stray), 0);
    chk("rst_done", 32'({a_done, b_done}), 0);
    reset = 1;
  endtask

  initial begin
    int beats;
    reset = 0;
    idle_inputs();
    apply_reset();

    // A alone, 4 pixels: 8 beats, results at stream offsets 3/5/7 and one in DRAIN.
    adv(); a_req = 1; a_len = 4; #2;
    chk("t1_idle_grant", 32'(grant), 1);
    adv(); #2;
    chk("t1_setup_inen", 32'(cte_in_en), 0);
    chk("t1_setup_mode", 32'(cte_op_mode), 0);
    for (int i = 0; i < 8; i++) begin
      adv(); a_valid = 1; a_yuv = 8'(8'h10 + i);
      cte_out_valid = (i == 3 || i == 5 || i == 7); #2;
      chk("t1_inen", 32'(cte_in_en), 1);
      chk("t1_mode", 32'(cte_op_mode), 0);
      chk("t1_yuv", 32'(cte_yuv_in), 32'h10 + i);
      chk("t1_grant", 32'(grant), 1);
      chk("t1_aov", 32'(a_out_valid), (i == 3 || i == 5 || i == 7) ? 1 : 0);
      chk("t1_done_early", 32'(a_done), 0);
    end
    adv(); a_valid = 0; cte_out_valid = 0; #2;
    chk("t1_drain_ready", 32'(a_ready), 0);
    chk("t1_drain_done", 32'(a_done), 0);
    adv(); cte_out_valid = 1; #2;
    chk("t1_last_aov", 32'(a_out_valid), 1);
    chk("t1_last_done", 32'(a_done), 0);
    adv(); cte_out_valid = 0; a_req = 0; #2;
    chk("t1_done", 32'({b_done, a_done}), 1);
    chk("t1_done_grant", 32'(grant), 1);
    adv(); #2;
    chk("t1_end_grant", 32'(grant), 0);
    chk("t1_end_done", 32'(a_done), 0);

    // Simultaneous requests right after reset: A first, then B.
    apply_reset();
    adv(); a_req = 1; a_len = 1; b_req = 1; b_len = 1; b_rgb = 24'hA1B2C3; #2;
    chk("t2_first_grant", 32'(grant), 1);
    adv(); #2;
    chk("t2_a_setup_mode", 32'(cte_op_mode), 0);
    for (int i = 0; i < 2; i++) begin
      adv(); a_valid = 1; a_yuv = 8'(8'h20 + i); #2;
      chk("t2_a_inen", 32'(cte_in_en), 1);
      chk("t2_a_rgb_zero", 32'(cte_rgb_in), 0);
      chk("t2_b_ready", 32'(b_ready), 0);
    end
    adv(); a_valid = 0; cte_out_valid = 1; #2;
    chk("t2_a_ov", 32'({b_out_valid, a_out_valid}), 1);
    adv(); cte_out_valid = 0; a_req = 0; #2;
    chk("t2_a_done", 32'(a_done), 1);
    adv(); #2;
    chk("t2_b_idle_grant", 32'(grant), 2);
    chk("t2_b_idle_mode", 32'(cte_op_mode), 0);
    adv(); #2;
    chk("t2_b_setup_mode", 32'(cte_op_mode), 1);
    chk("t2_b_setup_inen", 32'(cte_in_en), 0);
    chk("t2_b_setup_grant", 32'(grant), 2);
    adv(); b_valid = 1; #2;
    chk("t2_b_inen", 32'(cte_in_en), 1);
    chk("t2_b_rgb", 32'(cte_rgb_in), 32'hA1B2C3);
    chk("t2_b_yuv_zero", 32'(cte_yuv_in), 0);
    chk("t2_a_ready", 32'(a_ready), 0);
    for (int i = 0; i < 2; i++) begin
      adv(); b_valid = 0; cte_out_valid = 1; #2;
      chk("t2_b_ov", 32'({b_out_valid, a_out_valid}), 2);
      chk("t2_b_done_early", 32'(b_done), 0);
    end
    adv(); cte_out_valid = 0; b_req = 0; #2;
    chk("t2_b_done", 32'(b_done), 1);
    adv(); #2;
    chk("t2_end_grant", 32'(grant), 0);

    // B, 3 pixels, busy high on even cycles; 6 results expected.
    adv(); b_req = 1; b_len = 3; #2;
    chk("t3_grant", 32'(grant), 2);
    adv();
    beats = 0;
    for (int k = 0; k <= 10; k++) begin
      adv(); b_valid = 1; b_rgb = 24'(k);
      cte_busy = (k < 6) && (k % 2 == 0);
      cte_out_valid = (k == 2 || k == 4 || (k >= 6 && k <= 9));
      if (k == 10) b_req = 0;
      #2;
      if (cte_in_en) beats++;
      chk("t3_ready", 32'(b_ready), (k < 6 && k % 2 == 1) ? 1 : 0);
      chk("t3_inen", 32'(cte_in_en), (k < 6 && k % 2 == 1) ? 1 : 0);
      chk("t3_bov", 32'(b_out_valid), (k == 2 || k == 4 || (k >= 6 && k <= 9)) ? 1 : 0);
      chk("t3_done", 32'(b_done), (k == 10) ? 1 : 0);
    end
    chk("t3_beats", 32'(beats), 3);
    b_valid = 0; cte_busy = 0; cte_out_valid = 0;

    // Zero-length A burst.
    adv(); a_req = 1; a_len = 0; a_valid = 1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t4_grant", 32'(grant), 1);
      chk("t4_inen", 32'(cte_in_en), 0);
      chk("t4_done", 32'(a_done), (k == 2) ? 1 : 0);
      adv();
      if (k == 1) a_req = 0;
    end
    a_req = 0; a_valid = 0; #2;
    chk("t4_end_grant", 32'(grant), 0);
    chk("t4_end_done", 32'(a_done), 0);

    // Stray result while IDLE.
    adv(); cte_out_valid = 1; #2;
    chk("t5_ov", 32'({b_out_valid, a_out_valid}), 0);
    chk("t5_stray_pre", 32'(err_stray), 0);
    for (int k = 0; k < 3; k++) begin
      adv(); cte_out_valid = 0; #2;
      chk("t5_stray", 32'(err_stray), 1);
    end

    // Reset during A's STREAM, then B alone.
    adv(); a_req = 1; a_len = 4; #2;
    chk("t6_grant", 32'(grant), 1);
    adv();
    adv(); a_valid = 1; a_yuv = 8'h55; #2;
    chk("t6_inen", 32'(cte_in_en), 1);
    chk("t6_yuv", 32'(cte_yuv_in), 32'h55);
    adv(); reset = 0; #2;
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_ready", 32'(a_ready), 0);
    chk("t6_rst_inen", 32'(cte_in_en), 0);
    chk("t6_rst_yuv", 32'(cte_yuv_in), 0);
    chk("t6_rst_stray", 32'(err_stray), 0);
    chk("t6_rst_done", 32'(a_done), 0);
    adv(); reset = 1; a_req = 0; a_valid = 0; b_req = 1; b_len = 2; #2;
    chk("t6_b_grant", 32'(grant), 2);
    adv(); #2;
    chk("t6_b_mode", 32'(cte_op_mode), 1);
    chk("t6_b_setup_grant", 32'(grant), 2);
    apply_reset();

`ifdef CTE_ARB_WATCHDOG_EN
    // Withheld results: timeout on DRAIN cycle 64, DONE still issued.
    adv(); a_req = 1; a_len = 1;
    adv();
    adv(); a_valid = 1;
    adv();
    for (int n = 1; n <= 64; n++) begin
      adv(); a_valid = 0; #2;
      chk("wd_timeout_early", 32'(err_timeout), 0);
      chk("wd_done_early", 32'(a_done), 0);
    end
    adv(); a_req = 0; #2;
    chk("wd_timeout", 32'(err_timeout), 1);
    chk("wd_done", 32'(a_done), 1);
    adv(); #2;
    chk("wd_sticky", 32'(err_timeout), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
